id_operand_fetch: RTL and testbench
===================================

// Module: id_operand_fetch
// PURPOSE
//  Read-side partner of the WB stage. Owns the 32-entry integer register file.
//  Accepts decoded instructions, reads rs1/rs2 with a same-cycle WB bypass, and
//  tracks pending destination writes in a busy-bit scoreboard to stall on RAW hazards.
//  Holds operands in a valid/ready pipeline register that feeds EX.
// PARAMETERS
//  XLEN     32  data width of each register
//  NREGS    32  number of architectural registers; x0 is hardwired zero
//  REG_AW   5   register index width, equal to clog2(NREGS)
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-high reset
//  dec_valid    in   1       decoded instruction present
//  dec_ready    out  1       instruction accepted when dec_valid&&dec_ready
//  dec_rs1      in   REG_AW  source register 1 index
//  dec_rs2      in   REG_AW  source register 2 index
//  dec_rd       in   REG_AW  destination register index
//  dec_rd_wen   in   1       instruction writes rd
//  wb_wen       in   1       WB write enable
//  wb_rd        in   REG_AW  WB destination register
//  wb_data      in   XLEN    WB write data
//  flush        in   1       discard the instruction held for EX
//  ex_valid     out  1       operands valid for EX
//  ex_ready     in   1       EX consumes when ex_valid&&ex_ready
//  ex_rs1_data  out  XLEN    rs1 operand
//  ex_rs2_data  out  XLEN    rs2 operand
//  ex_rd        out  REG_AW  destination register forwarded to EX
//  ex_rd_wen    out  1       destination write enable forwarded to EX
// BEHAVIOUR
//  Reset: all registers 0, all busy bits 0, ex_valid=0; ex_* data=0.
//  Write port: on wb_wen && wb_rd!=0, regfile[wb_rd]<=wb_data at posedge.
//    Writes to x0 are ignored. Reads of x0 always return 0.
//  Read: combinational from the array. If wb_wen && wb_rd==rsN && rsN!=0,
//    wb_data is substituted in the same cycle (bypass).
//  Hazard: hazN = busy[rsN] && rsN!=0 && !(wb_wen && wb_rd==rsN).
//  dec_ready = !flush && !haz1 && !haz2 && (!ex_valid || ex_ready).
//    dec_ready has no combinational path from dec_valid.
//  Issue (dec_valid&&dec_ready): the pipe register captures operands, rd and
//    rd_wen; ex_valid<=1 next cycle. Latency is 1 cycle.
//  Drain: if ex_valid&&ex_ready and no issue, ex_valid<=0.
//    Issue and drain in the same cycle is legal: back-to-back, 1 instr/cycle.
//  While ex_valid&&!ex_ready, all ex_* outputs hold stable.
//  Scoreboard, per bit per cycle, in priority order:
//    - set: on issue with dec_rd_wen && dec_rd!=0.
//    - clear: on wb_wen for wb_rd.
//    - Set beats clear when both hit the same index in the same cycle.
//    - busy[0] is held at 0.
//  Flush: next cycle ex_valid<=0. If ex_valid&&ex_rd_wen, clear busy[ex_rd]
//    (the flushed instruction never writes). No issue occurs in the flush cycle.
//    Busy bits owned by instructions already past EX remain set and clear on WB.
//  Reset mid-operation: all state returns to reset values asynchronously.
//    Any in-flight instruction is lost.
//  WAW: dec_rd busy is not a hazard; the bit stays set until some WB to rd.
//    Downstream must retire in order.
// STRUCTURE
//  core_pkg:
//    - localparams XLEN, NREGS, REG_AW
//    - REG_ZERO=5'd0
//    - struct/typedef for the {rs1_data, rs2_data, rd, rd_wen} pipe payload
//  Sub-module regfile_2r1w (array, x0 rule, write-first bypass on both read ports).
//  The top level holds the scoreboard, the handshake and the pipe register.
// TESTING
//  1. Reset, then issue rs1=0, rs2=0, rd=0. Expect ex_rs1_data=ex_rs2_data=0,
//     ex_valid after 1 cycle, and no busy bit set.
//  2. WB write x5=0xDEADBEEF, and in the same cycle issue rs1=5.
//     Expect ex_rs1_data=0xDEADBEEF (bypass).
//  3. Issue rd=7 with wen. Next instruction has rs2=7: dec_ready=0 until
//     WB x7=0x12; in that WB cycle dec_ready=1 and ex_rs2_data=0x12.
//  4. Hold ex_ready=0 for 3 cycles with ex_valid=1. Expect ex_* stable and
//     dec_ready=0. Then ex_ready=1 with continuous dec_valid: one issue per cycle.
//  5. Issue rd=9 with wen while WB writes x9 in the same cycle.
//     Expect busy[9]=1 afterwards; a later rs1=9 stalls until the next WB to x9.
//  6. Issue rd=3, then flush while it is held (ex_ready=0). Expect ex_valid=0,
//     busy[3]=0, and a later rs1=3 issues without stall.
//     Assert reset mid-stall: ex_valid=0 and all registers read 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared widths and the operand-fetch pipe payload for the integer core.
package core_pkg;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [REG_AW-1:0] rd;
    logic              rd_wen;
  } op_pkt_t;
endpackage

// File: rtl/regfile_2r1w.sv
// Integer register file: 2 combinational read ports, 1 write port, x0 reads zero.
// A same-cycle write to the addressed register is forwarded to the read ports.
module regfile_2r1w
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wen,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wen && waddr != REG_ZERO) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == REG_ZERO)              rdata1 = '0;
    else if (wen && waddr == raddr1)     rdata1 = wdata;
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == REG_ZERO)              rdata2 = '0;
    else if (wen && waddr == raddr2)     rdata2 = wdata;
  end

endmodule

// File: rtl/id_operand_fetch.sv
// Operand fetch: regfile read with WB bypass, busy-bit RAW stall, 1-cycle pipe register to EX.
// Holds ex_* stable while EX stalls; dec_ready drops on hazard, flush or a full stalled pipe.
module id_operand_fetch
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_rd_wen,
  input  logic              wb_wen,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_rd_wen
);

  logic [XLEN-1:0]  rs1_data, rs2_data;
  logic [NREGS-1:0] busy, busy_nxt;
  logic             haz1, haz2, issue;
  op_pkt_t          pipe_q;

  regfile_2r1w u_regfile (
    .clk    (clk),
    .reset  (reset),
    .wen    (wb_wen),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (dec_rs1),
    .raddr2 (dec_rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  // A WB landing on the source this cycle resolves the hazard through the bypass.
  assign haz1 = busy[dec_rs1] && (dec_rs1 != REG_ZERO) && !(wb_wen && wb_rd == dec_rs1);
  assign haz2 = busy[dec_rs2] && (dec_rs2 != REG_ZERO) && !(wb_wen && wb_rd == dec_rs2);

  assign dec_ready = !flush && !haz1 && !haz2 && (!ex_valid || ex_ready);
  assign issue     = dec_valid && dec_ready;

  // Clears first so a same-cycle set on the same index wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_wen) busy_nxt[wb_rd] = 1'b0;
    if (flush && ex_valid && pipe_q.rd_wen) busy_nxt[pipe_q.rd] = 1'b0;
    if (issue && dec_rd_wen && dec_rd != REG_ZERO) busy_nxt[dec_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      pipe_q   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (issue) begin
      ex_valid        <= 1'b1;
      pipe_q.rs1_data <= rs1_data;
      pipe_q.rs2_data <= rs2_data;
      pipe_q.rd       <= dec_rd;
      pipe_q.rd_wen   <= dec_rd_wen;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  assign ex_rs1_data = pipe_q.rs1_data;
  assign ex_rs2_data = pipe_q.rs2_data;
  assign ex_rd       = pipe_q.rd;
  assign ex_rd_wen   = pipe_q.rd_wen;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed scenarios plus randomized traffic checked against a register/scoreboard model.
module tb_id_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_rd_wen;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_rd_wen;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_operand_fetch dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rd_wen(dec_rd_wen),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: architectural registers, pending-write set, one EX slot.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_vld;
  logic [31:0] m_rs1, m_rs2;
  logic [4:0]  m_rd;
  bit          m_rdw;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_busy[i] = 0; end
    m_vld = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rdw = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_wen && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit m_waits(input logic [4:0] r);
    return r != 0 && m_busy[r] && !(wb_wen && wb_rd == r);
  endfunction

  function automatic bit m_ready();
    return !flush && !m_waits(dec_rs1) && !m_waits(dec_rs2) && (!m_vld || ex_ready);
  endfunction

  function automatic void model_edge();
    bit take = dec_valid && m_ready();
    logic [31:0] a = m_read(dec_rs1);
    logic [31:0] b = m_read(dec_rs2);
    if (wb_wen) m_busy[wb_rd] = 0;
    if (flush && m_vld && m_rdw) m_busy[m_rd] = 0;
    if (take && dec_rd_wen && dec_rd != 0) m_busy[dec_rd] = 1;
    m_busy[0] = 0;
    if (wb_wen && wb_rd != 0) m_regs[wb_rd] = wb_data;
    if (flush) m_vld = 0;
    else if (take) begin
      m_vld = 1; m_rs1 = a; m_rs2 = b; m_rd = dec_rd; m_rdw = dec_rd_wen;
    end else if (ex_ready) m_vld = 0;
  endfunction

  task automatic drive(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input bit rdw);
    dec_valid = v; dec_rs1 = r1; dec_rs2 = r2; dec_rd = rd; dec_rd_wen = rdw;
  endtask

  task automatic wb(input bit w, input logic [4:0] rd, input logic [31:0] d);
    wb_wen = w; wb_rd = rd; wb_data = d;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0); wb(0, 0, 0); flush = 0;
  endtask

  // Inputs are set just after a negedge; one clock is stepped and outputs compared.
  task automatic cycle();
    #1;
    check("dec_ready", {31'd0, dec_ready}, {31'd0, m_ready()});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("ex_valid", {31'd0, ex_valid}, {31'd0, m_vld});
    if (m_vld) begin
      check("ex_rs1_data", ex_rs1_data, m_rs1);
      check("ex_rs2_data", ex_rs2_data, m_rs2);
      check("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
      check("ex_rd_wen", {31'd0, ex_rd_wen}, {31'd0, m_rdw});
    end
  endtask

  initial begin
    reset = 1; ex_ready = 1; idle();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_rs1", ex_rs1_data, 32'd0);
    check("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
    reset = 0;
    @(negedge clk);

    // 1: all-zero instruction
    drive(1, 0, 0, 0, 1); cycle();
    check("t1_valid", {31'd0, ex_valid}, 32'd1);
    check("t1_rs1", ex_rs1_data, 32'd0);
    check("t1_rs2", ex_rs2_data, 32'd0);
    idle(); drive(0, 0, 0, 0, 0); #1;
    check("t1_no_busy", {31'd0, dec_ready}, 32'd1);
    cycle();

    // 2: WB bypass into rs1
    wb(1, 5, 32'hDEADBEEF); drive(1, 5, 0, 1, 0); cycle();
    check("t2_bypass", ex_rs1_data, 32'hDEADBEEF);
    idle(); cycle();

    // 3: RAW stall on rs2 released by WB
    drive(1, 0, 0, 7, 1); cycle();
    drive(1, 0, 7, 8, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_stall", {31'd0, dec_ready}, 32'd0);
      cycle();
    end
    wb(1, 7, 32'h12); #1;
    check("t3_release", {31'd0, dec_ready}, 32'd1);
    cycle();
    check("t3_rs2", ex_rs2_data, 32'h12);
    idle(); cycle();

    // 4: EX backpressure then back-to-back issue
    ex_ready = 0; drive(1, 5, 7, 10, 0); cycle();
    drive(1, 0, 0, 11, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_hold_rs1", ex_rs1_data, 32'hDEADBEEF);
      check("t4_hold_rs2", ex_rs2_data, 32'h12);
      check("t4_hold_rd", {27'd0, ex_rd}, 32'd10);
      check("t4_ready_low", {31'd0, dec_ready}, 32'd0);
    end
    ex_ready = 1;
    for (int i = 11; i < 15; i++) begin
      drive(1, 0, 0, 5'(i), 0); cycle();
      check("t4_b2b_rd", {27'd0, ex_rd}, 32'(i));
      check("t4_b2b_vld", {31'd0, ex_valid}, 32'd1);
    end
    idle(); cycle();

    // 5: set beats clear on rd=9
    drive(1, 0, 0, 9, 1); wb(1, 9, 32'h99); cycle();
    idle(); drive(1, 9, 0, 1, 0); #1;
    check("t5_busy9", {31'd0, dec_ready}, 32'd0);
    cycle();
    wb(1, 9, 32'hAA); cycle();
    check("t5_rs1", ex_rs1_data, 32'hAA);
    idle(); cycle();

    // 6: flush clears the held instruction's busy bit
    ex_ready = 0; drive(1, 0, 0, 3, 1); cycle();
    idle(); flush = 1; cycle();
    check("t6_flushed", {31'd0, ex_valid}, 32'd0);
    flush = 0; drive(1, 3, 0, 0, 0); #1;
    check("t6_no_stall", {31'd0, dec_ready}, 32'd1);
    ex_ready = 1; cycle();
    idle(); cycle();

    // reset in the middle of a stall
    drive(1, 0, 0, 4, 1); ex_ready = 0; cycle();
    drive(1, 4, 0, 0, 0); cycle();
    #2 reset = 1;
    #1 check("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
    model_reset();
    @(negedge clk); reset = 0; ex_ready = 1;
    drive(1, 5, 7, 0, 0); cycle();
    check("rst_x5", ex_rs1_data, 32'd0);
    check("rst_x7", ex_rs2_data, 32'd0);
    drive(1, 4, 9, 0, 0); cycle();
    check("rst_x9", ex_rs2_data, 32'd0);

    // randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom % 2));
      wb(1'($urandom % 2), 5'($urandom_range(0, 7)), $urandom);
      ex_ready = ($urandom % 4) != 0;
      flush = ($urandom % 16) == 0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
